// File: rtl/sr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sr_ctrl_pkg
//   Shared types and default constants for the SR latch input conditioner.
//   - state_t              : pulse FSM states
//   - DEF_SYNC_STAGES      : synchroniser flops per raw input
//   - DEF_DB_CYCLES        : consecutive mismatching cycles before a debounced flip
//   - DEF_PULSE_W          : cycles S or R is held high per request
// -----------------------------------------------------------------------------
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE_S = 2'd1,
      DRIVE_R = 2'd2,
      GAP     = 2'd3
   } state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DB_CYCLES   = 4;
   localparam int DEF_PULSE_W     = 1;

endpackage

// File: rtl/sr_debounce.sv
// -----------------------------------------------------------------------------
// sr_debounce
//   One input channel: synchroniser chain, debounce counter and rising-edge
//   detector on the debounced level.
// Ports
//   CLK  in  1  clock, rising edge
//   RST  in  1  synchronous active-high reset
//   raw  in  1  asynchronous raw request line
//   req  out 1  one-cycle request on a rising edge of the debounced level
// -----------------------------------------------------------------------------
module sr_debounce
   import sr_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw,
   output logic req
);

   localparam int              CW       = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_out;
   logic [CW-1:0]          cnt;
   logic                   level;
   logic                   level_d;

   assign sync_out = sync[SYNC_STAGES-1];

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours; blocking here would collapse the
   // synchroniser chain into a single stage.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync    <= '0;
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], raw};
         level_d <= level;
         if (sync_out == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // Last of DB_CYCLES consecutive mismatches: accept the new level.
            level <= sync_out;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Falling edges of the debounced level are deliberately ignored.
   assign req = level & ~level_d;

endmodule

// File: rtl/sr_pulse_ctrl.sv
// -----------------------------------------------------------------------------
// sr_pulse_ctrl
//   Input conditioner for an SR latch. Two raw asynchronous request lines are
//   synchronised and debounced; the resulting requests drive mutually exclusive
//   S/R pulses separated by a dead-time GAP cycle. Q_TRACK models the latch Q.
//   Optional feature macro: SR_CONFLICT_FLAG_EN
//     defined   : CONFLICT port exists; simultaneous set+clear drops both and
//                 pulses CONFLICT for one cycle.
//     undefined : no CONFLICT port; simultaneous set+clear resolves to set.
// Ports
//   CLK      in  1  clock, rising edge
//   RST      in  1  synchronous active-high reset
//   SET_BTN  in  1  raw set request (asynchronous, active-high)
//   CLR_BTN  in  1  raw clear request (asynchronous, active-high)
//   S        out 1  set pulse to the latch
//   R        out 1  reset pulse to the latch
//   Q_TRACK  out 1  registered model of the latch Q
//   BUSY     out 1  high while the FSM is not IDLE
//   CONFLICT out 1  one-cycle pulse on simultaneous set+clear (macro only)
// -----------------------------------------------------------------------------
module sr_pulse_ctrl
   import sr_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES,
   parameter int PULSE_W     = DEF_PULSE_W
) (
   input  logic CLK,
   input  logic RST,
   input  logic SET_BTN,
   input  logic CLR_BTN,
   output logic S,
   output logic R,
   output logic Q_TRACK,
   output logic BUSY
`ifdef SR_CONFLICT_FLAG_EN
   ,
   output logic CONFLICT
`endif
);

   localparam int              PW_W    = $clog2(PULSE_W + 1);
   localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_W - 1);

   state_t          state, state_nxt;
   logic [PW_W-1:0] pcnt, pcnt_nxt;
   logic            pend_s, pend_s_nxt;
   logic            pend_r, pend_r_nxt;
   logic            q_reg, q_nxt;
   logic            req_s, req_r;
   logic            eff_s, eff_r;
`ifdef SR_CONFLICT_FLAG_EN
   logic            conf_reg, conf_nxt;
`endif

   sr_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
   ) u_db_set (
      .CLK (CLK),
      .RST (RST),
      .raw (SET_BTN),
      .req (req_s)
   );

   sr_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
   ) u_db_clr (
      .CLK (CLK),
      .RST (RST),
      .raw (CLR_BTN),
      .req (req_r)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         pcnt   <= '0;
         pend_s <= 1'b0;
         pend_r <= 1'b0;
         q_reg  <= 1'b0;
`ifdef SR_CONFLICT_FLAG_EN
         conf_reg <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         pcnt   <= pcnt_nxt;
         pend_s <= pend_s_nxt;
         pend_r <= pend_r_nxt;
         q_reg  <= q_nxt;
`ifdef SR_CONFLICT_FLAG_EN
         conf_reg <= conf_nxt;
`endif
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      pcnt_nxt   = pcnt;
      pend_s_nxt = pend_s;
      pend_r_nxt = pend_r;
      q_nxt      = q_reg;
`ifdef SR_CONFLICT_FLAG_EN
      conf_nxt   = 1'b0;
`endif
      eff_s      = req_s | pend_s;
      eff_r      = req_r | pend_r;

      // Requests that arrive while a pulse or gap is in progress are parked.
      if (state != IDLE) begin
         pend_s_nxt = pend_s | req_s;
         pend_r_nxt = pend_r | req_r;
      end

      case (state)
         IDLE: begin
            pcnt_nxt = '0;
            if (eff_s && eff_r) begin
               pend_s_nxt = 1'b0;
               pend_r_nxt = 1'b0;
`ifdef SR_CONFLICT_FLAG_EN
               conf_nxt   = 1'b1;
`else
               state_nxt  = DRIVE_S;
               q_nxt      = 1'b1;
`endif
            end else if (eff_s) begin
               state_nxt  = DRIVE_S;
               pend_s_nxt = 1'b0;
               q_nxt      = 1'b1;
            end else if (eff_r) begin
               state_nxt  = DRIVE_R;
               pend_r_nxt = 1'b0;
               q_nxt      = 1'b0;
            end
         end
         DRIVE_S, DRIVE_R: begin
            if (pcnt == PW_LAST) begin
               state_nxt = GAP;
               pcnt_nxt  = '0;
            end else begin
               pcnt_nxt  = pcnt + 1'b1;
            end
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from registered state only, so S and R are glitch-free
   // and can never be high together.
   assign S       = (state == DRIVE_S);
   assign R       = (state == DRIVE_R);
   assign BUSY    = (state != IDLE);
   assign Q_TRACK = q_reg;
`ifdef SR_CONFLICT_FLAG_EN
   assign CONFLICT = conf_reg;
`endif

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sr_pulse_ctrl
//   Self-checking bench for sr_pulse_ctrl. A reference model driven from the
//   raw input history predicts each pulse (kind, start edge, width, Q_TRACK)
//   and pushes it to a scoreboard queue; a monitor pops and compares whenever
//   the DUT emits a pulse. A second instance with PULSE_W=3 covers reset in the
//   middle of a pulse.
// -----------------------------------------------------------------------------
module tb_sr_pulse_ctrl;

   localparam int SYNC = 2;
   localparam int DB   = 4;
   localparam int PW   = 1;
   localparam int PW6  = 3;
   localparam int MAXE = 4096;

   logic CLK = 1'b0;
   logic RST, SET_BTN, CLR_BTN;
   logic S, R, Q_TRACK, BUSY;
   logic RST6, SET6;
   logic CLR6 = 1'b0;
   logic S6, R6, Q6, BUSY6;
   logic conf_mon;
`ifdef SR_CONFLICT_FLAG_EN
   logic CONFLICT, CONFLICT6;
   assign conf_mon = CONFLICT;
`else
   assign conf_mon = 1'b0;
`endif

   always #5 CLK = ~CLK;

   int pos_cnt = 0;
   always @(posedge CLK) pos_cnt <= pos_cnt + 1;

   sr_pulse_ctrl #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .PULSE_W(PW)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .SET_BTN  (SET_BTN),
      .CLR_BTN  (CLR_BTN),
      .S        (S),
      .R        (R),
      .Q_TRACK  (Q_TRACK),
      .BUSY     (BUSY)
`ifdef SR_CONFLICT_FLAG_EN
      ,
      .CONFLICT (CONFLICT)
`endif
   );

   sr_pulse_ctrl #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .PULSE_W(PW6)) dut6 (
      .CLK      (CLK),
      .RST      (RST6),
      .SET_BTN  (SET6),
      .CLR_BTN  (CLR6),
      .S        (S6),
      .R        (R6),
      .Q_TRACK  (Q6),
      .BUSY     (BUSY6)
`ifdef SR_CONFLICT_FLAG_EN
      ,
      .CONFLICT (CONFLICT6)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d (edge %0d)", name, act, exp, pos_cnt - 1);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct {
      int kind;   // 1 = S, 2 = R, 3 = CONFLICT
      int start;  // edge after which the output first goes high
      int width;
      int q;
   } ev_t;

   ev_t exp_q[$];
   bit  hist_s [MAXE];
   bit  hist_r [MAXE];
   bit  exp_busy [MAXE];
   int  rst_edge = -1;
   bit  lvl_s, lvl_r;
   int  lf_s = -1, lf_r = -1;   // edge of the last debounced flip (or reset)
   bit  nreq_s, nreq_r;         // request visible at the next edge
   bit  pend_s, pend_r;
   int  free_at = 0;            // first edge at which the FSM is IDLE again

   // Value presented by the synchroniser at edge k: the raw sample taken
   // SYNC edges earlier, or 0 if that sample predates the last reset.
   function automatic bit sync_val(input bit ch, input int k);
      int idx;
      idx = k - SYNC;
      if (idx < 0 || idx <= rst_edge) return 1'b0;
      return ch ? hist_r[idx] : hist_s[idx];
   endfunction

   // Level flips at edge k when the last DB synchronised samples, all taken
   // after the previous flip, disagree with the current level.
   function automatic bit db_flip(input bit ch, input int k, input bit lvl, input int lf);
      if (k - lf < DB) return 1'b0;
      for (int j = 0; j < DB; j++)
         if (sync_val(ch, k - j) == lvl) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive(input int kind, input int e);
      exp_q.push_back('{kind: kind, start: e, width: PW, q: (kind == 1) ? 1 : 0});
      for (int k = e; k <= e + PW; k++) exp_busy[k] = 1'b1;
      free_at = e + PW + 2;
   endtask

   task automatic model_edge(input int e, input bit s, input bit c, input bit rst);
      bit rs, rr, es, er;
      hist_s[e] = s;
      hist_r[e] = c;
      if (rst) begin
         rst_edge = e;
         lvl_s = 1'b0; lvl_r = 1'b0;
         lf_s = e; lf_r = e;
         nreq_s = 1'b0; nreq_r = 1'b0;
         pend_s = 1'b0; pend_r = 1'b0;
         free_at = 0;
         for (int k = e; k <= e + PW + 2; k++) exp_busy[k] = 1'b0;
         return;
      end
      rs = nreq_s;
      rr = nreq_r;
      if (e < free_at) begin
         pend_s = pend_s | rs;
         pend_r = pend_r | rr;
      end else begin
         es = rs | pend_s;
         er = rr | pend_r;
         if (es && er) begin
            pend_s = 1'b0;
            pend_r = 1'b0;
`ifdef SR_CONFLICT_FLAG_EN
            exp_q.push_back('{kind: 3, start: e, width: 1, q: 0});
`else
            drive(1, e);
`endif
         end else if (es) begin
            pend_s = 1'b0;
            drive(1, e);
         end else if (er) begin
            pend_r = 1'b0;
            drive(2, e);
         end
      end
      nreq_s = 1'b0;
      if (db_flip(1'b0, e, lvl_s, lf_s)) begin
         lvl_s = !lvl_s; lf_s = e; nreq_s = lvl_s;
      end
      nreq_r = 1'b0;
      if (db_flip(1'b1, e, lvl_r, lf_r)) begin
         lvl_r = !lvl_r; lf_r = e; nreq_r = lvl_r;
      end
   endtask

   // Apply inputs for the coming edge, advance the model, wait one cycle.
   task automatic step(input bit s, input bit c, input bit rst);
      SET_BTN = s;
      CLR_BTN = c;
      RST     = rst;
      model_edge(pos_cnt, s, c, rst);
      @(negedge CLK);
   endtask

   task automatic hold(input bit s, input bit c, input int n);
      for (int i = 0; i < n; i++) step(s, c, 1'b0);
   endtask

   // -------------------------------------------------------------- monitor
   int act_kind  = 0;
   int act_start = 0;
   int act_q     = 0;
   bit prev_s    = 1'b0;
   bit prev_r    = 1'b0;

   task automatic finish_event(input int kind, input int start, input int width, input int q);
      ev_t ev;
      if (exp_q.size() == 0) begin
         check("unexpected_pulse_kind", kind, 0);
      end else begin
         ev = exp_q.pop_front();
         check("pulse_kind", kind, ev.kind);
         check("pulse_start", start, ev.start);
         check("pulse_width", width, ev.width);
         if (ev.kind != 3) check("pulse_q_track", q, ev.q);
      end
   endtask

   always @(negedge CLK) begin : monitor
      int e;
      int kind_now;
      e = pos_cnt - 1;
      kind_now = S ? 1 : (R ? 2 : (conf_mon ? 3 : 0));
      check("s_r_exclusive_and_gapped", int'((S && R) || (S && prev_r) || (R && prev_s)), 0);
      check("busy", int'(BUSY), int'(exp_busy[e]));
      if (kind_now != act_kind) begin
         if (act_kind != 0) finish_event(act_kind, act_start, e - act_start, act_q);
         act_kind  = kind_now;
         act_start = e;
         act_q     = int'(Q_TRACK);
      end
      prev_s = S;
      prev_r = R;
   end

   // -------------------------------------------------------------- stimulus
   initial begin
      bit s, c, seen;
      int len;
      RST = 1'b1; SET_BTN = 1'b0; CLR_BTN = 1'b0;
      RST6 = 1'b1; SET6 = 1'b0;

      // Reset held with SET_BTN high: all outputs stay low.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1);
         check("reset_s", int'(S), 0);
         check("reset_r", int'(R), 0);
         check("reset_q_track", int'(Q_TRACK), 0);
         check("reset_busy", int'(BUSY), 0);
      end

      // SET held after reset: single S pulse, Q_TRACK set.
      hold(1'b1, 1'b0, 16);
      check("set_q_track", int'(Q_TRACK), 1);
      hold(1'b0, 1'b0, 12);

      // Glitch shorter than the debounce window: no pulse, counter back to 0.
      hold(1'b1, 1'b0, 3);
      hold(1'b0, 1'b0, 10);
      check("glitch_db_cnt", int'(dut.u_db_set.cnt), 0);
      check("glitch_q_track", int'(Q_TRACK), 1);

      // SET, then CLR two cycles after S: R follows after a gap.
      hold(1'b1, 1'b0, 9);
      hold(1'b1, 1'b1, 14);
      check("clear_q_track", int'(Q_TRACK), 0);
      hold(1'b0, 1'b0, 12);

      // Simultaneous SET and CLR.
      hold(1'b1, 1'b1, 12);
`ifdef SR_CONFLICT_FLAG_EN
      check("both_q_track", int'(Q_TRACK), 0);
`else
      check("both_q_track", int'(Q_TRACK), 1);
`endif
      hold(1'b0, 1'b0, 12);

      // Randomised level segments.
      for (int seg = 0; seg < 150; seg++) begin
         s   = 1'($urandom_range(0, 1));
         c   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 12);
         hold(s, c, len);
      end
      hold(1'b0, 1'b0, 20);
      check("scoreboard_drained", exp_q.size(), 0);
      check("no_open_pulse", act_kind, 0);

      // PULSE_W=3 instance: reset during the second cycle of DRIVE_S.
      RST6 = 1'b0;
      SET6 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1'b0, 1'b0, 1'b0);
         seen = S6;
      end
      check("pw3_s_seen", int'(seen), 1);
      if (seen) begin
         step(1'b0, 1'b0, 1'b0);
         check("pw3_s_cycle2", int'(S6), 1);
         check("pw3_q_cycle2", int'(Q6), 1);
         RST6 = 1'b1;
         step(1'b0, 1'b0, 1'b0);
         check("pw3_rst_s", int'(S6), 0);
         check("pw3_rst_r", int'(R6), 0);
         check("pw3_rst_busy", int'(BUSY6), 0);
         check("pw3_rst_q", int'(Q6), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
